// File: rtl/prg_loader.sv
// Download loader: streams data_io bytes into memory for ROM/program/other files, then
// patches the program end address into the configured pointer locations.
module prg_loader #(
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] ROM_BASE  = '0,
  parameter logic [15:0]       PRG_BASE  = 16'h8133,
  parameter logic [15:0]       PRG_LIMIT = 16'hFFFF,
  parameter logic [7:0]        PRG_IDX_A = 8'h01,
  parameter logic [7:0]        PRG_IDX_B = 8'h41,
  parameter int                PTR_N     = 1,
  parameter logic [15:0]       PTR_ADDR0 = 16'h81BB,
  parameter logic [15:0]       PTR_ADDR1 = 16'h0000,
  parameter logic [15:0]       PTR_ADDR2 = 16'h0000,
  parameter logic [15:0]       PTR_ADDR3 = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic [7:0]        dl_index,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              mem_ready,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              downloading,
  output logic              rom_done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, LOAD, PATCH, FINISH} state_t;
  typedef enum logic [1:0] {KIND_ROM, KIND_PRG, KIND_OTHER} kind_t;

  localparam logic [2:0] LAST_IDX = 3'(2 * PTR_N - 1);

  state_t            state_reg, state_next;
  kind_t             kind_reg, kind_next, kind_in;
  logic [16:0]       len_reg, len_next, len_cand;
  logic [2:0]        idx_reg, idx_next, idx_plus;
  logic              error_reg, error_next;
  logic              rom_done_reg, rom_done_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic [ADDR_W:0]   prg_sum;
  logic              prg_ovf;
  logic [15:0]       end_val;

  // Patch byte k: pointer k/2, low byte first then high byte at the next address.
  function automatic logic [ADDR_W-1:0] patch_addr(input logic [2:0] k);
    logic [15:0] base;
    case (k[2:1])
      2'd0:    base = PTR_ADDR0;
      2'd1:    base = PTR_ADDR1;
      2'd2:    base = PTR_ADDR2;
      default: base = PTR_ADDR3;
    endcase
    return ADDR_W'(base + 16'(k[0]));
  endfunction

  function automatic logic [7:0] patch_data(input logic [2:0] k, input logic [15:0] v);
    return k[0] ? v[15:8] : v[7:0];
  endfunction

  assign kind_in  = (dl_index == 8'h00) ? KIND_ROM :
                    ((dl_index == PRG_IDX_A) || (dl_index == PRG_IDX_B)) ? KIND_PRG : KIND_OTHER;
  // Overflow check is done one bit wider so large offsets cannot wrap below the limit.
  assign prg_sum  = {1'b0, ADDR_W'(PRG_BASE)} + {1'b0, dl_addr};
  assign prg_ovf  = prg_sum > (ADDR_W + 1)'(PRG_LIMIT);
  assign len_cand = 17'(dl_addr) + 17'd1;
  assign end_val  = PRG_BASE + len_reg[15:0];
  assign idx_plus = idx_reg + 3'd1;

  always_comb begin
    state_next    = state_reg;
    kind_next     = kind_reg;
    len_next      = len_reg;
    idx_next      = idx_reg;
    error_next    = error_reg;
    rom_done_next = rom_done_reg;
    wr_next       = 1'b0;
    addr_next     = addr_reg;
    data_next     = data_reg;
    unique case (state_reg)
      IDLE: begin
        if (dl_active) begin
          state_next = LOAD;
          kind_next  = kind_in;
          len_next   = '0;
          if (kind_in == KIND_PRG) error_next = 1'b0;
        end
      end
      LOAD: begin
        if (!dl_active) begin
          idx_next = '0;
          if (kind_reg == KIND_PRG) begin
            state_next = PATCH;
            wr_next    = 1'b1;
            addr_next  = patch_addr(3'd0);
            data_next  = patch_data(3'd0, end_val);
          end else begin
            state_next = FINISH;
          end
        end else if (dl_wr) begin
          data_next = dl_data;
          case (kind_reg)
            KIND_ROM: begin
              wr_next   = 1'b1;
              addr_next = ROM_BASE + dl_addr;
            end
            KIND_PRG: begin
              if (prg_ovf) begin
                error_next = 1'b1;
              end else begin
                wr_next   = 1'b1;
                addr_next = prg_sum[ADDR_W-1:0];
                if (len_cand > len_reg) len_next = len_cand;
              end
            end
            default: begin
              wr_next   = 1'b1;
              addr_next = dl_addr;
            end
          endcase
        end
      end
      PATCH: begin
        wr_next = 1'b1;
        if (mem_ready) begin
          if (idx_reg == LAST_IDX) begin
            wr_next    = 1'b0;
            state_next = FINISH;
          end else begin
            idx_next  = idx_plus;
            addr_next = patch_addr(idx_plus);
            data_next = patch_data(idx_plus, end_val);
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
        if (kind_reg == KIND_ROM) rom_done_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      kind_reg     <= KIND_OTHER;
      len_reg      <= '0;
      idx_reg      <= '0;
      error_reg    <= 1'b0;
      rom_done_reg <= 1'b0;
      wr_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      kind_reg     <= kind_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      error_reg    <= error_next;
      rom_done_reg <= rom_done_next;
      wr_reg       <= wr_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
    end
  end

  assign wr          = wr_reg;
  assign addr        = addr_reg;
  assign data        = data_reg;
  assign downloading = (state_reg == LOAD) || (state_reg == PATCH);
  assign rom_done    = rom_done_reg;
  assign error       = error_reg;

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader: default instance plus a narrow-limit, two-pointer instance.
module tb_prg_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_active = 1'b0;
  logic [7:0]  dl_index = 8'h00;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = 8'h00;
  logic        mem_ready = 1'b1;

  logic        wr, downloading, rom_done, error;
  logic [24:0] addr;
  logic [7:0]  data;
  logic        wr2, downloading2, rom_done2, error2;
  logic [24:0] addr2;
  logic [7:0]  data2;

  int vectors = 0;
  int miscompares = 0;

  logic [24:0] log_a[$];
  logic [7:0]  log_d[$];
  logic [24:0] log2_a[$];
  logic [7:0]  log2_d[$];

  always #5 clk = ~clk;

  prg_loader dut (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .mem_ready(mem_ready),
    .wr(wr), .addr(addr), .data(data), .downloading(downloading),
    .rom_done(rom_done), .error(error)
  );

  prg_loader #(.PRG_LIMIT(16'h8134), .PTR_N(2), .PTR_ADDR1(16'h81BD)) dut2 (
    .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .mem_ready(mem_ready),
    .wr(wr2), .addr(addr2), .data(data2), .downloading(downloading2),
    .rom_done(rom_done2), .error(error2)
  );

  // Memory-side view: a write lands when wr is high with mem_ready at the edge.
  always @(posedge clk) begin
    if (wr && mem_ready) begin log_a.push_back(addr); log_d.push_back(data); end
    if (wr2 && mem_ready) begin log2_a.push_back(addr2); log2_d.push_back(data2); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_byte(input logic [24:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    vectors++;
    if ({wr, addr, data, downloading, rom_done, error} !== 37'h0) begin
      $display("FAIL reset_state got wr=%b addr=%h data=%h dl=%b rd=%b err=%b exp all zero",
               wr, addr, data, downloading, rom_done, error);
      miscompares++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_rom();
    dl_index = 8'h00; dl_active = 1'b1; mem_ready = 1'b1;
    tick();
    vectors++;
    if (downloading !== 1'b1) begin
      $display("FAIL rom_enter got downloading=%b exp 1", downloading); miscompares++;
    end
    drive_byte(25'h0, 8'hAA);
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h0, 8'hAA}) begin
      $display("FAIL rom_byte0 got wr=%b addr=%h data=%h exp 1/0/AA", wr, addr, data); miscompares++;
    end
    drive_byte(25'h1, 8'hBB);
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h1, 8'hBB}) begin
      $display("FAIL rom_byte1 got wr=%b addr=%h data=%h exp 1/1/BB", wr, addr, data); miscompares++;
    end
    tick();
    vectors++;
    if ({wr, downloading} !== 2'b01) begin
      $display("FAIL rom_gap got wr=%b dl=%b exp 0/1", wr, downloading); miscompares++;
    end
    dl_active = 1'b0;
    tick();
    vectors++;
    if ({wr, downloading, rom_done} !== 3'b000) begin
      $display("FAIL rom_finish got wr=%b dl=%b rd=%b exp 0/0/0", wr, downloading, rom_done); miscompares++;
    end
    tick();
    vectors++;
    if (rom_done !== 1'b1) begin
      $display("FAIL rom_done got %b exp 1", rom_done); miscompares++;
    end
    idle(3);
  endtask

  task automatic test_prg();
    logic [24:0] ea [5];
    logic [7:0]  ed [5];
    logic [24:0] offs [3];
    ea = '{25'h8135, 25'h8133, 25'h8134, 25'h81BB, 25'h81BC};
    ed = '{8'h10, 8'h11, 8'h12, 8'h36, 8'h81};
    offs = '{25'h2, 25'h0, 25'h1};
    log_a.delete(); log_d.delete();
    dl_index = 8'h01; dl_active = 1'b1; mem_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_byte(offs[i], ed[i]);
      vectors++;
      if ({wr, addr, data} !== {1'b1, ea[i], ed[i]}) begin
        $display("FAIL prg_byte%0d got wr=%b addr=%h data=%h exp 1/%h/%h", i, wr, addr, data, ea[i], ed[i]);
        miscompares++;
      end
    end
    tick();
    dl_active = 1'b0;
    tick();
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h81BB, 8'h36}) begin
      $display("FAIL prg_patch_lo got wr=%b addr=%h data=%h exp 1/81bb/36", wr, addr, data); miscompares++;
    end
    tick();
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h81BC, 8'h81}) begin
      $display("FAIL prg_patch_hi got wr=%b addr=%h data=%h exp 1/81bc/81", wr, addr, data); miscompares++;
    end
    tick();
    vectors++;
    if ({wr, downloading, error} !== 3'b000) begin
      $display("FAIL prg_finish got wr=%b dl=%b err=%b exp 0/0/0", wr, downloading, error); miscompares++;
    end
    vectors++;
    if (log_a.size() != 5) begin
      $display("FAIL prg_write_count got %0d exp 5", log_a.size()); miscompares++;
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if ({log_a[i], log_d[i]} !== {ea[i], ed[i]}) begin
          $display("FAIL prg_log%0d got %h/%h exp %h/%h", i, log_a[i], log_d[i], ea[i], ed[i]);
          miscompares++;
        end
      end
    end
    idle(6);
  endtask

  task automatic test_backpressure();
    log_a.delete(); log_d.delete();
    dl_index = 8'h41; dl_active = 1'b1; mem_ready = 1'b1;
    tick();
    drive_byte(25'h0, 8'h55);
    tick();
    dl_active = 1'b0; mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({wr, addr, data} !== {1'b1, 25'h81BB, 8'h34}) begin
        $display("FAIL bp_hold%0d got wr=%b addr=%h data=%h exp 1/81bb/34", i, wr, addr, data); miscompares++;
      end
      tick();
    end
    mem_ready = 1'b1;
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h81BB, 8'h34}) begin
      $display("FAIL bp_release got wr=%b addr=%h data=%h exp 1/81bb/34", wr, addr, data); miscompares++;
    end
    tick();
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h81BC, 8'h81}) begin
      $display("FAIL bp_hi got wr=%b addr=%h data=%h exp 1/81bc/81", wr, addr, data); miscompares++;
    end
    tick();
    vectors++;
    if (wr !== 1'b0) begin
      $display("FAIL bp_finish got wr=%b exp 0", wr); miscompares++;
    end
    vectors++;
    if (log_a.size() != 3) begin
      $display("FAIL bp_write_count got %0d exp 3", log_a.size()); miscompares++;
    end else begin
      vectors++;
      if ({log_a[1], log_d[1], log_a[2], log_d[2]} !== {25'h81BB, 8'h34, 25'h81BC, 8'h81}) begin
        $display("FAIL bp_log got %h/%h %h/%h exp 81bb/34 81bc/81", log_a[1], log_d[1], log_a[2], log_d[2]);
        miscompares++;
      end
    end
    idle(6);
  endtask

  task automatic test_overflow();
    logic [24:0] ea [6];
    logic [7:0]  ed [6];
    ea = '{25'h8133, 25'h8134, 25'h81BB, 25'h81BC, 25'h81BD, 25'h81BE};
    ed = '{8'hA0, 8'hA1, 8'h35, 8'h81, 8'h35, 8'h81};
    log2_a.delete(); log2_d.delete();
    dl_index = 8'h01; dl_active = 1'b1; mem_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_byte(25'(i), 8'hA0 + 8'(i));
      vectors++;
      if (i < 2 && {wr2, addr2, data2} !== {1'b1, ea[i], ed[i]}) begin
        $display("FAIL ovf_byte%0d got wr=%b addr=%h data=%h exp 1/%h/%h", i, wr2, addr2, data2, ea[i], ed[i]);
        miscompares++;
      end else if (i >= 2 && {wr2, error2} !== 2'b01) begin
        $display("FAIL ovf_suppress%0d got wr=%b err=%b exp 0/1", i, wr2, error2); miscompares++;
      end
    end
    tick();
    dl_active = 1'b0;
    for (int i = 2; i < 6; i++) begin
      tick();
      vectors++;
      if ({wr2, addr2, data2} !== {1'b1, ea[i], ed[i]}) begin
        $display("FAIL ovf_patch%0d got wr=%b addr=%h data=%h exp 1/%h/%h", i - 2, wr2, addr2, data2, ea[i], ed[i]);
        miscompares++;
      end
    end
    tick();
    vectors++;
    if ({wr2, downloading2, error2} !== 3'b001) begin
      $display("FAIL ovf_finish got wr=%b dl=%b err=%b exp 0/0/1", wr2, downloading2, error2); miscompares++;
    end
    vectors++;
    if (log2_a.size() != 6) begin
      $display("FAIL ovf_write_count got %0d exp 6", log2_a.size()); miscompares++;
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if ({log2_a[i], log2_d[i]} !== {ea[i], ed[i]}) begin
          $display("FAIL ovf_log%0d got %h/%h exp %h/%h", i, log2_a[i], log2_d[i], ea[i], ed[i]);
          miscompares++;
        end
      end
    end
    idle(6);
  endtask

  task automatic test_zero_len();
    dl_index = 8'h01; dl_active = 1'b1; mem_ready = 1'b1;
    tick();
    vectors++;
    if (error2 !== 1'b0) begin
      $display("FAIL zero_err_clear got %b exp 0", error2); miscompares++;
    end
    dl_active = 1'b0;
    tick();
    vectors++;
    if ({wr, addr, data, wr2, addr2, data2} !== {1'b1, 25'h81BB, 8'h33, 1'b1, 25'h81BB, 8'h33}) begin
      $display("FAIL zero_patch_lo got %h/%h %h/%h exp 81bb/33 both", addr, data, addr2, data2); miscompares++;
    end
    tick();
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h81BC, 8'h81}) begin
      $display("FAIL zero_patch_hi got wr=%b addr=%h data=%h exp 1/81bc/81", wr, addr, data); miscompares++;
    end
    idle(6);
  endtask

  task automatic test_other();
    log_a.delete(); log_d.delete();
    dl_index = 8'h05; dl_active = 1'b1; mem_ready = 1'b1;
    tick();
    drive_byte(25'h123, 8'h5A);
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h123, 8'h5A}) begin
      $display("FAIL other_byte got wr=%b addr=%h data=%h exp 1/123/5a", wr, addr, data); miscompares++;
    end
    tick();
    dl_active = 1'b0;
    tick();
    idle(3);
    vectors++;
    if (log_a.size() != 1 || downloading !== 1'b0) begin
      $display("FAIL other_no_patch got writes=%0d dl=%b exp 1/0", log_a.size(), downloading); miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    log_a.delete(); log_d.delete();
    dl_index = 8'h01; dl_active = 1'b1; mem_ready = 1'b1;
    tick();
    drive_byte(25'h0, 8'h77);
    tick();
    dl_active = 1'b0;
    tick();
    vectors++;
    if ({wr, addr, data} !== {1'b1, 25'h81BB, 8'h34}) begin
      $display("FAIL rst_patch_lo got wr=%b addr=%h data=%h exp 1/81bb/34", wr, addr, data); miscompares++;
    end
    tick();
    reset_n = 1'b0; mem_ready = 1'b0;
    tick();
    vectors++;
    if ({wr, downloading, addr, data, rom_done} !== 36'h0) begin
      $display("FAIL rst_abort got wr=%b dl=%b addr=%h data=%h rd=%b exp zero", wr, downloading, addr, data, rom_done);
      miscompares++;
    end
    reset_n = 1'b1; mem_ready = 1'b1;
    idle(5);
    vectors++;
    if (log_a.size() != 2 || wr !== 1'b0) begin
      $display("FAIL rst_no_more_writes got writes=%0d wr=%b exp 2/0", log_a.size(), wr); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_rom();
    test_prg();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_other();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
